snax_tcdm_responder: RTL and testbench

SNAX_TCDM_RESPONDER -- requirements
Module: snax_tcdm_responder

---
 rtl/snax_tcdm_responder_pkg.sv | 37 +++
 rtl/snax_tcdm_rsp_pipe.sv | 32 +++
 rtl/snax_tcdm_responder.sv | 82 ++++++++
 tb/tb_snax_tcdm_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snax_tcdm_responder_pkg.sv
// snax_tcdm_responder_pkg: shared types and constants for the TCDM responder
// Holds the default request/response structs, the RspLatency legal range and
// the back-pressure LFSR seed/taps (used when SNAX_TCDM_RSP_STALL_EN is defined).
package snax_tcdm_responder_pkg;
  localparam int RSP_LAT_MIN = 1;
  localparam int RSP_LAT_MAX = 4;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  typedef enum logic [3:0] {
    AMONone, AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
    AMOMax, AMOMaxu, AMOMin, AMOMinu, AMOLR, AMOSC
  } amo_op_e;
  typedef struct packed {
    logic [16:0] addr;
    logic        write;
    amo_op_e     amo;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        user;
  } tcdm_req_chan_t;
  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_default_t;
  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_t;
  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_default_t;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/snax_tcdm_rsp_pipe.sv
// snax_tcdm_rsp_pipe: fixed-latency valid/data delay line for read responses
// Ports: clk_i, rst_i (async, active-high, clears valids only),
//        valid_i/data_i in, valid_o/data_o out Depth cycles later (data_o is 0 when !valid_o).
module snax_tcdm_rsp_pipe
  import snax_tcdm_responder_pkg::*;
#(
  parameter int Depth     = RSP_LAT_MIN,
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);
  logic [Depth-1:0]     vld_q;
  logic [DataWidth-1:0] dat_q [Depth];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= '0;
    else begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < Depth; i++) vld_q[i] <= vld_q[i-1];
    end
  end
  always_ff @(posedge clk_i) begin
    dat_q[0] <= data_i;
    for (int i = 1; i < Depth; i++) dat_q[i] <= dat_q[i-1];
  end
  assign valid_o = vld_q[Depth-1];
  assign data_o  = valid_o ? dat_q[Depth-1] : '0;
endmodule

// File: rtl/snax_tcdm_responder.sv
// snax_tcdm_responder: TCDM memory model answering streamer requests with fixed read latency
// Ports: clk_i, rst_i (async, active-high); tcdm_req_i request (addr/write/amo/data/strb/user, q_valid);
//        tcdm_rsp_o (q_ready, p_valid, p.data); req_count_o saturating accepted-request count.
// Option: define SNAX_TCDM_RSP_STALL_EN to drive q_ready from an 8-bit LFSR for back-pressure.
module snax_tcdm_responder
  import snax_tcdm_responder_pkg::*;
#(
  parameter type tcdm_req_t    = tcdm_req_default_t,
  parameter type tcdm_rsp_t    = tcdm_rsp_default_t,
  parameter int  TCDMDataWidth = 64,
  parameter int  TCDMAddrWidth = 17,
  parameter int  NumWords      = 512,
  parameter int  RspLatency    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  tcdm_req_t   tcdm_req_i,
  output tcdm_rsp_t   tcdm_rsp_o,
  output logic [31:0] req_count_o
);
  localparam int NumBytes = TCDMDataWidth / 8;
  localparam int OffW     = $clog2(NumBytes);
  localparam int IdxW     = $clog2(NumWords);
  if (RspLatency < RSP_LAT_MIN || RspLatency > RSP_LAT_MAX) begin : g_bad_lat
    $error("RspLatency must lie in 1..4");
  end
  if (OffW + IdxW > TCDMAddrWidth) begin : g_bad_addr
    $error("address too narrow for NumWords");
  end
  logic                     q_ready;
  logic                     acc;
  logic [IdxW-1:0]          idx;
  logic [31:0]              cnt_q, cnt_d;
  logic [TCDMDataWidth-1:0] mem_q [NumWords];
  logic                     p_valid;
  logic [TCDMDataWidth-1:0] p_data;
  logic                     unused_ok;
`ifdef SNAX_TCDM_RSP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = lfsr_step(lfsr_q);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
  end
  assign q_ready = ~rst_i & lfsr_q[0];
`else
  assign q_ready = ~rst_i;
`endif
  assign acc       = tcdm_req_i.q_valid & q_ready;
  // Word index; offset bits and bits above the array wrap are dropped.
  assign idx       = tcdm_req_i.q.addr[OffW +: IdxW];
  assign unused_ok = ^{tcdm_req_i.q.addr, tcdm_req_i.q.amo, tcdm_req_i.q.user};
  assign cnt_d     = (acc && ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  always_ff @(posedge clk_i) begin
    if (acc && tcdm_req_i.q.write)
      for (int b = 0; b < NumBytes; b++)
        if (tcdm_req_i.q.strb[b]) mem_q[idx][8*b +: 8] <= tcdm_req_i.q.data[8*b +: 8];
  end
  // Read data is sampled at the accept edge, before any later write can land.
  snax_tcdm_rsp_pipe #(
    .Depth    (RspLatency),
    .DataWidth(TCDMDataWidth)
  ) i_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(acc & ~tcdm_req_i.q.write),
    .data_i (mem_q[idx]),
    .valid_o(p_valid),
    .data_o (p_data)
  );
  always_comb begin
    tcdm_rsp_o          = '0;
    tcdm_rsp_o.q_ready  = q_ready;
    tcdm_rsp_o.p_valid  = p_valid;
    tcdm_rsp_o.p.data   = p_data;
  end
  assign req_count_o = cnt_q;
endmodule

// File: tb/tb_snax_tcdm_responder.sv
// tb_snax_tcdm_responder: randomized scoreboard bench for snax_tcdm_responder
module tb_snax_tcdm_responder;
  import snax_tcdm_responder_pkg::*;
  localparam int LAT = 3;
  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  logic              clk = 0;
  logic              rst = 1;
  tcdm_req_default_t req;
  tcdm_rsp_default_t rsp;
  logic [31:0]       cnt;
  logic [63:0]       ref_mem [512];
  logic [7:0]        ref_lfsr = 8'hA5;
  logic [31:0]       ref_cnt = 0;
  exp_t              exp_q [$];
  int                cyc = 0;
  int                n_acc = 0;
  int                n_pv = 0;
  int                n_chk = 0;
  int                n_err = 0;
  int                pv0;
  logic [63:0]       last_rdata = '0;
`ifdef SNAX_TCDM_RSP_STALL_EN
  logic [7:0]        pl;
  int                pred;
  int                a0;
`endif
  always #5 clk = ~clk;
  snax_tcdm_responder #(
    .tcdm_req_t   (tcdm_req_default_t),
    .tcdm_rsp_t   (tcdm_rsp_default_t),
    .TCDMDataWidth(64),
    .TCDMAddrWidth(17),
    .NumWords     (512),
    .RspLatency   (LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tcdm_req_i (req),
    .tcdm_rsp_o (rsp),
    .req_count_o(cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit exp_rdy();
`ifdef SNAX_TCDM_RSP_STALL_EN
    return !rst && ref_lfsr[0];
`else
    return !rst;
`endif
  endfunction
  // Reference model: behavioural memory, FIFO of expected read responses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      ref_cnt = 0;
      ref_lfsr = 8'hA5;
    end else begin
      cyc++;
      if (req.q_valid && exp_rdy()) begin
        int idx;
        n_acc++;
        if (ref_cnt != 32'hFFFF_FFFF) ref_cnt++;
        idx = (int'(req.q.addr) / 8) % 512;
        if (req.q.write) begin
          for (int b = 0; b < 8; b++)
            if (req.q.strb[b]) ref_mem[idx][8*b +: 8] = req.q.data[8*b +: 8];
        end else exp_q.push_back('{ref_mem[idx], cyc + LAT - 1});
      end
      ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end
  end
  always @(posedge clk) begin
    bit exp_v;
    #2;
    if (rst) begin
      chk("rst_q_ready", rsp.q_ready, 0);
      chk("rst_p_valid", rsp.p_valid, 0);
      chk("rst_p_data", rsp.p.data, 0);
      chk("rst_count", cnt, 0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rsp_missing_at", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      exp_v = exp_q.size() > 0 && exp_q[0].due == cyc;
      chk("p_valid", rsp.p_valid, exp_v);
      if (rsp.p_valid) begin
        n_pv++;
        last_rdata = rsp.p.data;
      end
      if (exp_v) begin
        chk("p_data", rsp.p.data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else chk("p_data_idle", rsp.p.data, 0);
      chk("q_ready", rsp.q_ready, exp_rdy());
      chk("req_count", cnt, ref_cnt);
    end
  end
  task automatic issue(input bit wr, input logic [16:0] a, input logic [63:0] d, input logic [7:0] s);
    int n0;
    n0 = n_acc;
    req.q.write = wr;
    req.q.addr  = a;
    req.q.data  = d;
    req.q.strb  = s;
    req.q.amo   = amo_op_e'($urandom_range(0, 11));
    req.q.user  = 1'($urandom);
    req.q_valid = 1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (n_acc != n0) return;
    end
    chk("accept_timeout", n_acc, n0 + 1);
  endtask
  task automatic idle(input int n);
    req.q_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    req.q_valid = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  initial begin
    req = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1 chk("ready_after_release", rsp.q_ready, 1);
    for (int w = 0; w < 512; w++) issue(1, 17'(w * 8), {$urandom, $urandom}, 8'hFF);
    issue(1, 17'h40, 64'h1122_3344_5566_7788, 8'hFF);
    issue(0, 17'h40, '0, '0);
    idle(LAT + 2);
    chk("rd_0x40", last_rdata, 64'h1122_3344_5566_7788);
    issue(1, 17'h08, 64'h0, 8'hFF);
    issue(1, 17'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    issue(0, 17'h08, '0, '0);
    idle(LAT + 2);
    chk("strb_low_half", last_rdata, 64'h0000_0000_FFFF_FFFF);
    issue(1, 17'h1008, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    issue(0, 17'h08, '0, '0);
    idle(LAT + 2);
    chk("alias_hi_to_lo", last_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    issue(1, 17'h08, 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue(0, 17'h1008, '0, '0);
    idle(LAT + 2);
    chk("alias_lo_to_hi", last_rdata, 64'h0123_4567_89AB_CDEF);
    do_reset();
    pv0 = n_pv;
    for (int i = 0; i < 16; i++) issue(0, 17'(i * 8), '0, '0);
    idle(LAT + 2);
    chk("b2b_count", cnt, 16);
    chk("b2b_pulses", n_pv - pv0, 16);
    do_reset();
    issue(0, 17'h40, '0, '0);
    issue(0, 17'h48, '0, '0);
    pv0 = n_pv;
    rst = 1;
    req.q_valid = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_count", cnt, 0);
    rst = 0;
    #1 chk("mid_rst_ready", rsp.q_ready, 1);
    idle(8);
    chk("mid_rst_no_pvalid", n_pv, pv0);
    chk("mid_rst_count_after", cnt, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(1'($urandom), 17'($urandom), {$urandom, $urandom}, 8'($urandom));
    end
`ifdef SNAX_TCDM_RSP_STALL_EN
    do_reset();
    pl = 8'hA5;
    pred = 0;
    for (int c = 0; c < 255; c++) begin
      pred += int'(pl[0]);
      pl = {pl[6:0], pl[7] ^ pl[5] ^ pl[4] ^ pl[3]};
    end
    req.q.write = 0;
    req.q.addr  = 17'($urandom);
    req.q_valid = 1;
    for (int c = 0; c < 255; c++) begin
      a0 = n_acc;
      @(negedge clk);
      if (n_acc != a0) req.q.addr = 17'($urandom);
    end
    req.q_valid = 0;
    chk("stall_accepts", cnt, pred);
`endif
    idle(LAT + 4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
